// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module  : pipe_ctrl_pkg
// Purpose : Shared FSM encodings, mult/div latencies and hazard helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

   localparam int MD_CNT_W = 4;

   localparam logic [MD_CNT_W-1:0] MD_MULT_CYC = 4'd5;
   localparam logic [MD_CNT_W-1:0] MD_DIV_CYC  = 4'd10;
   localparam logic [1:0]          TUSE_NONE   = 2'd3;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      STALL_DATA = 2'd1,
      STALL_MD   = 2'd2,
      FLUSH      = 2'd3
   } state_t;

   // A consumer must wait when its operand is needed before the producer has it.
   function automatic logic operand_hazard(input logic [4:0] src,
                                           input logic [1:0] tuse,
                                           input logic [4:0] a3,
                                           input logic [1:0] tnew);
      return (src != 5'd0) && (src == a3) && (tuse != TUSE_NONE) && (tuse < tnew);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_busy_cnt.sv
// ============================================================================
// Module  : md_busy_cnt
// Purpose : Occupancy counter for the multi-cycle mult/div unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module md_busy_cnt
   import pipe_ctrl_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic e_md_start,
   input  logic e_md_div,
   output logic md_busy
);

   logic [MD_CNT_W-1:0] r_md_cnt;
   logic                w_idle;

   assign w_idle = (r_md_cnt == '0);

   // A start while the unit is still counting is dropped; the stall upstream prevents it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_md_cnt <= '0;
      end else if (e_md_start && w_idle) begin
         r_md_cnt <= e_md_div ? MD_DIV_CYC : MD_MULT_CYC;
      end else if (!w_idle) begin
         r_md_cnt <= r_md_cnt - 4'd1;
      end
   end

   assign md_busy = !w_idle || e_md_start;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module  : pipe_ctrl
// Purpose : Hazard detection, stall/flush control and stall statistics.
//           Define PIPE_CTRL_MDU_EN to include the mult/div busy tracking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic        d_is_md,
   input  logic [4:0]  e_a3,
   input  logic [1:0]  e_tnew,
   input  logic [4:0]  m_a3,
   input  logic [1:0]  m_tnew,
   input  logic        e_md_start,
   input  logic        e_md_div,
   input  logic        req_exc,
   input  logic        req_eret,
   output logic        fd_en,
   output logic        de_clr,
   output logic        flush_all,
   output logic        md_busy,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_stall_cnt;
   logic        w_data_haz;
   logic        w_md_haz;
   logic        w_stall;

`ifdef PIPE_CTRL_MDU_EN
   md_busy_cnt u_md_busy_cnt (
      .clk        (clk),
      .reset      (reset),
      .e_md_start (e_md_start),
      .e_md_div   (e_md_div),
      .md_busy    (md_busy)
   );

   assign w_md_haz = d_is_md && md_busy;
`else
   logic w_unused_md;

   assign w_unused_md = ^{e_md_start, e_md_div, d_is_md};
   assign md_busy     = 1'b0;
   assign w_md_haz    = 1'b0;
`endif

   assign w_data_haz = operand_hazard(d_rs, d_tuse_rs, e_a3, e_tnew)
                    || operand_hazard(d_rs, d_tuse_rs, m_a3, m_tnew)
                    || operand_hazard(d_rt, d_tuse_rt, e_a3, e_tnew)
                    || operand_hazard(d_rt, d_tuse_rt, m_a3, m_tnew);

   assign flush_all = req_exc || req_eret;

   // The cycle after a flush only holds bubbles, so nothing can need a stall.
   assign w_stall = (w_data_haz || w_md_haz) && !flush_all && (r_state != FLUSH);
   assign fd_en   = !w_stall;
   assign de_clr  = w_stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = RUN;
      if (flush_all) begin
         w_state_nxt = FLUSH;
      end else if (w_md_haz) begin
         w_state_nxt = STALL_MD;
      end else if (w_data_haz) begin
         w_state_nxt = STALL_DATA;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign state     = r_state;
   assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module  : tb_pipe_ctrl
// Purpose : Directed self-checking bench for pipe_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, e_a3, m_a3;
   logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic        d_is_md, e_md_start, e_md_div, req_exc, req_eret;
   logic        fd_en, de_clr, flush_all, md_busy;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .d_rs       (d_rs),
      .d_rt       (d_rt),
      .d_tuse_rs  (d_tuse_rs),
      .d_tuse_rt  (d_tuse_rt),
      .d_is_md    (d_is_md),
      .e_a3       (e_a3),
      .e_tnew     (e_tnew),
      .m_a3       (m_a3),
      .m_tnew     (m_tnew),
      .e_md_start (e_md_start),
      .e_md_div   (e_md_div),
      .req_exc    (req_exc),
      .req_eret   (req_eret),
      .fd_en      (fd_en),
      .de_clr     (de_clr),
      .flush_all  (flush_all),
      .md_busy    (md_busy),
      .state      (state),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
      e_a3 = 5'd0; e_tnew = 2'd0; m_a3 = 5'd0; m_tnew = 2'd0;
      e_md_start = 1'b0; e_md_div = 1'b0; req_exc = 1'b0; req_eret = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;
      #2;
      check("rst_state", state, 0);
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_md_busy", md_busy, 0);
      check("rst_fd_en", fd_en, 1);
      check("rst_de_clr", de_clr, 0);
      check("rst_flush", flush_all, 0);
      step();
      reset = 1'b0;

      // E-stage rs hazard
      d_rs = 5'd5; d_tuse_rs = 2'd0; e_a3 = 5'd5; e_tnew = 2'd2;
      #1;
      check("e_rs_de_clr", de_clr, 1);
      check("e_rs_fd_en", fd_en, 0);
      step();
      check("e_rs_state", state, 1);
      check("e_rs_cnt", stall_cnt, 1);
      d_rs = 5'd0;
      #1;
      check("rs_zero_no_stall", de_clr, 0);
      step();
      check("rs_zero_state", state, 0);
      check("rs_zero_cnt", stall_cnt, 1);

      // M-stage rt hazard and the tuse==tnew boundary
      clear_inputs();
      d_rt = 5'd7; d_tuse_rt = 2'd1; m_a3 = 5'd7; m_tnew = 2'd2;
      #1;
      check("m_rt_stall", de_clr, 1);
      d_tuse_rt = 2'd2;
      #1;
      check("m_rt_equal_no_stall", de_clr, 0);
      d_tuse_rt = 2'd3; m_tnew = 2'd3;
      #1;
      check("m_rt_unused_no_stall", de_clr, 0);
      d_rt = 5'd8; d_tuse_rt = 2'd0; m_tnew = 2'd2;
      #1;
      check("m_rt_other_reg", de_clr, 0);

      // Exception while a data hazard is pending
      clear_inputs();
      d_rs = 5'd9; d_tuse_rs = 2'd1; e_a3 = 5'd9; e_tnew = 2'd3;
      req_exc = 1'b1;
      #1;
      check("exc_flush", flush_all, 1);
      check("exc_no_stall", de_clr, 0);
      step();
      check("exc_state_flush", state, 3);
      check("exc_cnt_hold", stall_cnt, 1);
      req_exc = 1'b0;
      #1;
      check("flush_state_no_stall", de_clr, 0);
      check("flush_state_fd_en", fd_en, 1);
      d_rs = 5'd0;
      step();
      check("flush_to_run", state, 0);
      req_eret = 1'b1;
      #1;
      check("eret_flush", flush_all, 1);
      step();
      req_eret = 1'b0;
      check("eret_state", state, 3);
      step();
      check("eret_back_run", state, 0);
      check("flush_cnt_hold", stall_cnt, 1);

`ifdef PIPE_CTRL_MDU_EN
      // Divide with a mult/div consumer waiting in D
      clear_inputs();
      do_reset();
      check("md_idle_at_issue", md_busy, 0);
      d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
      #1;
      check("div_busy_issue", md_busy, 1);
      check("div_stall_issue", de_clr, 1);
      step();
      e_md_start = 1'b0; e_md_div = 1'b0;
      check("div_state", state, 2);
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("div_busy_%0d", i), md_busy, 1);
         step();
      end
      check("div_done", md_busy, 0);
      check("div_no_stall", de_clr, 0);
      check("div_stall_cnt", stall_cnt, 11);

      // Asynchronous reset during a mult
      clear_inputs();
      check("mult_idle_at_issue", md_busy, 0);
      e_md_start = 1'b1;
      step();
      e_md_start = 1'b0;
      d_is_md = 1'b1;
      step();
      step();
      check("mult_busy_pre_rst", md_busy, 1);
      check("mult_state_pre_rst", state, 2);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_busy", md_busy, 0);
      check("async_rst_state", state, 0);
      check("async_rst_cnt", stall_cnt, 0);
      step();
      reset = 1'b0;
      clear_inputs();
      step();
`else
      // Mult/div inputs must have no effect
      clear_inputs();
      d_is_md = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
      #1;
      check("nomdu_busy", md_busy, 0);
      check("nomdu_no_stall", de_clr, 0);
      step();
      e_md_start = 1'b0;
      #1;
      check("nomdu_busy_after", md_busy, 0);
      check("nomdu_state", state, 0);
      check("nomdu_cnt", stall_cnt, 1);
      clear_inputs();
`endif

      // Long stall: saturation at 16'hFFFF
      do_reset();
      d_rs = 5'd3; d_tuse_rs = 2'd0; m_a3 = 5'd3; m_tnew = 2'd1;
      for (int i = 0; i < 65534; i++) step();
      check("sat_fffe", stall_cnt, 16'hFFFE);
      step();
      check("sat_ffff", stall_cnt, 16'hFFFF);
      for (int i = 0; i < 4470; i++) step();
      check("sat_hold", stall_cnt, 16'hFFFF);
      check("sat_state", state, 1);
      check("sat_still_stall", de_clr, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
